rand_bcd_display: RTL and testbench
===================================

Name: rand_bcd_display

Overview:
- Consumes the 8-bit pseudo-random value from the LFSR stage and presents it on the board's seven-segment displays.
- Converts each accepted value to three decimal digits using a sequential double-dabble (shift-and-add-3) FSM, one shift per cycle.
- Also drives two hex digits and exposes the packed BCD result.
- Sits directly downstream of the LFSR: upstream asserts in_valid with rand_num when it wants a new value shown.

Parameters:
- DW, 8, binary input width; BCD digit count is fixed at 3, so legal DW is 1..9 (2^DW <= 1000).
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board default); 0 = active-high.
- BLANK_LZ, 1, 1 = blank leading zeros on the hundreds/tens digits; the ones digit is never blanked.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a value to display.
- in_data  input  DW  value to convert (LFSR rand_num).
- in_ready  output  1  block can accept; high only in IDLE.
- out_valid  output  1  one-cycle pulse: a new result was just committed.
- out_bcd  output  12  {hundreds, tens, ones}, 4 bits each, held.
- seg_h  output  7  hundreds digit segments, bit0=a … bit6=g.
- seg_t  output  7  tens digit segments.
- seg_o  output  7  ones digit segments.
- seg_xh  output  7  hex digit for in_data[7:4], zero-extended when DW<8.
- seg_xl  output  7  hex digit for in_data[3:0].

Behaviour:
- Reset: async, active-high. clk and rst are the only clock and reset.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_bcd=0, held hex value=0.
  - Reset clears any in-flight conversion; no out_valid is produced for it.
- Displays are combinational from the held registers (out_bcd, held hex value). Reset display with defaults: seg_o="0", seg_h/seg_t blank, seg_xh/seg_xl="0".
- FSM states are IDLE and CONV.
  - IDLE: in_ready=1. On in_valid&&in_ready at edge k:
    - Latch shift register = in_data, work BCD = 0, count = 0.
    - Latch in_data into the hex-hold register at the same edge.
    - Go to CONV.
  - CONV: in_ready=0; in_valid and in_data are ignored.
    - Each cycle: every work nibble >= 5 gets +3, then {bcd, bin} shifts left by 1; count++.
    - On the DW-th shift (edge k+DW): commit the shifted BCD to out_bcd, set out_valid=1 for one cycle, return to IDLE.
- Latency: out_valid is high in the cycle following edge k+DW, i.e. DW cycles after acceptance.
- in_ready is high during that same cycle, so back-to-back accept is allowed at edge k+DW+1. Throughput is one value per DW+1 cycles.
- The hex-hold register updates at accept, not at commit. The hex digits may therefore lead the decimal digits by DW cycles.
- Segment encoding, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, b=7C, C=39, d=5E, E=79, F=71
- If SEG_ACTIVE_LOW=1, outputs are the bitwise inverse. Blank = all segments off (7F when active-low).
- Leading-zero blanking (BLANK_LZ=1):
  - seg_h is blank when hundreds=0.
  - seg_t is blank when hundreds=0 and tens=0.
- A BCD nibble > 9 cannot occur for legal DW. The decoder maps 10-15 to blank as a defensive default.
- in_valid asserted while in_ready=0 has no effect. Upstream must hold the value or re-request.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CONV)
  - the 16-entry active-high segment table and the SEG_BLANK constant
  - the BCD digit count constant (3)
- One combinational sub-module, seg7_hex_dec: 4-bit nibble + blank + active_low in, 7-bit segments out. It is instantiated five times.
- FSM and datapath live in the top.

Test Plan:
- Reset with defaults → in_ready=1, out_valid=0, out_bcd=000, seg_o=40, seg_t=7F, seg_h=7F, seg_xh=40, seg_xl=40.
- in_data=FF accepted at edge k → in_ready=0 for 8 cycles; out_valid pulses once after edge k+8; out_bcd=255; seg_h=24, seg_t=12, seg_o=12, seg_xh=seg_xl=0E.
- in_data=07 → out_bcd=007; seg_h=7F, seg_t=7F, seg_o=78; seg_xh=40, seg_xl=78.
- in_data=64 (100) → out_bcd=100; seg_h=79, seg_t=40 (not blanked), seg_o=40.
- in_valid held high with in_data changing every cycle during CONV → only the value at the accepting edge converts; next accept occurs exactly at edge k+9 (out_valid cycle).
- rst pulsed during the 4th CONV cycle → FSM returns to IDLE immediately, out_valid never pulses, all outputs return to reset values; the next accept converts correctly (e.g. 2A → 042).

Source files
------------

// File: rtl/rand_bcd_display_pkg.sv
// Shared constants for the random-number BCD display slice:
// FSM encodings, seven-segment table and the double-dabble adjust step.
package rand_bcd_display_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t CONV = 1'b1;

    // Active-high gfedcba, index 15 first so SEG_TABLE[n] is digit n.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [BCD_W-1:0] dabble_adjust(
        input logic [BCD_W-1:0] bcd
    );
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble to seven-segment decoder with forced blank and polarity select.
// Combinational; shared by the decimal and hex digit drivers.
module seg7_hex_dec
    import rand_bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] seg
);

    logic [6:0] seg_ah;

    always_comb begin
        seg_ah = blank ? SEG_BLANK : SEG_TABLE[nibble];
        seg    = active_low ? ~seg_ah : seg_ah;
    end

endmodule

// File: rtl/rand_bcd_display.sv
// Converts accepted LFSR values to three BCD digits by sequential
// double-dabble and drives three decimal and two hex segment digits.
module rand_bcd_display
    import rand_bcd_display_pkg::*;
#(
    parameter int DW             = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [11:0]   out_bcd,
    output logic [6:0]    seg_h,
    output logic [6:0]    seg_t,
    output logic [6:0]    seg_o,
    output logic [6:0]    seg_xh,
    output logic [6:0]    seg_xl
);

    localparam int            CW   = 4;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t              state_q;
    logic [DW-1:0]       bin_q;
    logic [BCD_W-1:0]    work_q;
    logic [CW-1:0]       cnt_q;
    logic [7:0]          hex_q;
    logic [7:0]          hex_d;

    logic                accept;
    logic                last_shift;
    logic [BCD_W-1:0]    work_adj;
    logic [BCD_W+DW-1:0] shifted;
    logic [BCD_W-1:0]    work_nx;
    logic [DW-1:0]       bin_nx;

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign last_shift = (cnt_q == LAST);

    // One shift-and-add-3 step across the joined {bcd, bin} register.
    assign work_adj = dabble_adjust(work_q);
    assign shifted  = {work_adj, bin_q} << 1;
    assign work_nx  = shifted[BCD_W+DW-1:DW];
    assign bin_nx   = shifted[DW-1:0];

    if (DW >= 8) begin : g_hex_trunc
        assign hex_d = in_data[7:0];
    end else begin : g_hex_ext
        assign hex_d = {{(8-DW){1'b0}}, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            hex_q     <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bin_q   <= in_data;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        hex_q   <= hex_d;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bin_q  <= bin_nx;
                    work_q <= work_nx;
                    cnt_q  <= cnt_q + 4'd1;
                    if (last_shift) begin
                        out_bcd   <= work_nx;
                        out_valid <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [3:0] dig_h;
    logic [3:0] dig_t;
    logic [3:0] dig_o;
    logic       blank_h;
    logic       blank_t;
    logic       blank_o;

    assign dig_h = out_bcd[11:8];
    assign dig_t = out_bcd[7:4];
    assign dig_o = out_bcd[3:0];

    // Non-decimal nibbles blank rather than show a hex letter.
    assign blank_h = (dig_h > 4'd9)
                   || (BLANK_LZ && dig_h == 4'd0);
    assign blank_t = (dig_t > 4'd9)
                   || (BLANK_LZ && dig_h == 4'd0 && dig_t == 4'd0);
    assign blank_o = (dig_o > 4'd9);

    seg7_hex_dec u_dec_h (
        .nibble     (dig_h),
        .blank      (blank_h),
        .active_low (SEG_ACTIVE_LOW),
        .seg        (seg_h)
    );

    seg7_hex_dec u_dec_t (
        .nibble     (dig_t),
        .blank      (blank_t),
        .active_low (SEG_ACTIVE_LOW),
        .seg        (seg_t)
    );

    seg7_hex_dec u_dec_o (
        .nibble     (dig_o),
        .blank      (blank_o),
        .active_low (SEG_ACTIVE_LOW),
        .seg        (seg_o)
    );

    seg7_hex_dec u_dec_xh (
        .nibble     (hex_q[7:4]),
        .blank      (1'b0),
        .active_low (SEG_ACTIVE_LOW),
        .seg        (seg_xh)
    );

    seg7_hex_dec u_dec_xl (
        .nibble     (hex_q[3:0]),
        .blank      (1'b0),
        .active_low (SEG_ACTIVE_LOW),
        .seg        (seg_xl)
    );

endmodule

// File: tb/tb_rand_bcd_display.sv
// Bench for rand_bcd_display: directed table, random values against a
// divide/modulo reference, held-valid and mid-conversion reset sequences.
module tb_rand_bcd_display;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_bcd;
    logic [6:0]  seg_h;
    logic [6:0]  seg_t;
    logic [6:0]  seg_o;
    logic [6:0]  seg_xh;
    logic [6:0]  seg_xl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rand_bcd_display #(
        .DW             (DW),
        .SEG_ACTIVE_LOW (1'b1),
        .BLANK_LZ       (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .seg_h     (seg_h),
        .seg_t     (seg_t),
        .seg_o     (seg_o),
        .seg_xh    (seg_xh),
        .seg_xl    (seg_xl)
    );

    typedef struct {
        logic [7:0]  din;
        logic [11:0] bcd;
        logic [6:0]  h;
        logic [6:0]  t;
        logic [6:0]  o;
        logic [6:0]  xh;
        logic [6:0]  xl;
    } vec_t;

    vec_t vecs[5];

    // Active-low segment pattern for a digit, or all-off when blanked.
    function automatic logic [6:0] ref_seg(int d, bit blank);
        logic [6:0] s;
        if (blank) return 7'h7F;
        case (d)
            0: s = 7'h3F;   1: s = 7'h06;   2: s = 7'h5B;
            3: s = 7'h4F;   4: s = 7'h66;   5: s = 7'h6D;
            6: s = 7'h7D;   7: s = 7'h07;   8: s = 7'h7F;
            9: s = 7'h6F;  10: s = 7'h77;  11: s = 7'h7C;
           12: s = 7'h39;  13: s = 7'h5E;  14: s = 7'h79;
           15: s = 7'h71;
            default: s = 7'h00;
        endcase
        return ~s;
    endfunction

    function automatic vec_t ref_model(logic [7:0] v);
        vec_t r;
        int vi, h, t, o;
        vi    = int'(v);
        h     = vi / 100;
        t     = (vi / 10) % 10;
        o     = vi % 10;
        r.din = v;
        r.bcd = 12'(h * 256 + t * 16 + o);
        r.h   = ref_seg(h, h == 0);
        r.t   = ref_seg(t, h == 0 && t == 0);
        r.o   = ref_seg(o, 1'b0);
        r.xh  = ref_seg(vi / 16, 1'b0);
        r.xl  = ref_seg(vi % 16, 1'b0);
        return r;
    endfunction

    task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, vec_t e);
        chk({tag, ".bcd"}, out_bcd, e.bcd);
        chk({tag, ".seg_h"}, 12'(seg_h), 12'(e.h));
        chk({tag, ".seg_t"}, 12'(seg_t), 12'(e.t));
        chk({tag, ".seg_o"}, 12'(seg_o), 12'(e.o));
        chk({tag, ".seg_xh"}, 12'(seg_xh), 12'(e.xh));
        chk({tag, ".seg_xl"}, 12'(seg_xl), 12'(e.xl));
    endtask

    // Wait for the out_valid pulse, returning the number of edges taken.
    task automatic wait_result(string tag, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (!out_valid && in_ready !== 1'b0) begin
                chk({tag, ".busy"}, 12'(in_ready), 12'd0);
            end
        end
    endtask

    task automatic do_convert(string tag, vec_t e);
        int n;
        @(negedge clk);
        chk({tag, ".ready_pre"}, 12'(in_ready), 12'd1);
        in_valid = 1'b1;
        in_data  = e.din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        chk({tag, ".ready_busy"}, 12'(in_ready), 12'd0);
        chk({tag, ".xh_lead"}, 12'(seg_xh), 12'(e.xh));
        chk({tag, ".xl_lead"}, 12'(seg_xl), 12'(e.xl));
        wait_result(tag, n);
        chk({tag, ".latency"}, 12'(n), 12'(DW));
        check_outs(tag, e);
        chk({tag, ".ready_at_valid"}, 12'(in_ready), 12'd1);
        @(posedge clk); #1;
        chk({tag, ".valid_pulse"}, 12'(out_valid), 12'd0);
    endtask

    vec_t rst_vec;
    vec_t ea;
    vec_t eb;
    int   n;
    int   pulses;

    initial begin
        vecs[0] = '{8'hFF, 12'h255, 7'h24, 7'h12, 7'h12, 7'h0E, 7'h0E};
        vecs[1] = '{8'h07, 12'h007, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h78};
        vecs[2] = '{8'h64, 12'h100, 7'h79, 7'h40, 7'h40, 7'h02, 7'h19};
        vecs[3] = '{8'h00, 12'h000, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
        vecs[4] = '{8'h0A, 12'h010, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h08};
        rst_vec = '{8'h00, 12'h000, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 12'(in_ready), 12'd1);
        chk("rst.valid", 12'(out_valid), 12'd0);
        check_outs("rst", rst_vec);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_convert($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 30; i++) begin
            do_convert($sformatf("rnd%0d", i),
                       ref_model(8'($urandom_range(0, 255))));
        end

        // Held in_valid with changing data: only the accepted value converts.
        ea = ref_model(8'hC3);
        eb = ref_model(8'h5E);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = ea.din;
        @(posedge clk); #1;
        for (int i = 1; i <= DW; i++) begin
            @(negedge clk);
            in_data = 8'($urandom);
            @(posedge clk); #1;
            if (i < DW) begin
                chk("hold.busy", 12'(in_ready), 12'd0);
            end
        end
        chk("hold.valid", 12'(out_valid), 12'd1);
        chk("hold.ready", 12'(in_ready), 12'd1);
        chk("hold.bcd_a", out_bcd, ea.bcd);
        @(negedge clk);
        in_data = eb.din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hold.reaccept", 12'(in_ready), 12'd0);
        chk("hold.xh_b", 12'(seg_xh), 12'(eb.xh));
        chk("hold.xl_b", 12'(seg_xl), 12'(eb.xl));
        wait_result("hold_b", n);
        chk("hold.lat_b", 12'(n), 12'(DW));
        check_outs("hold_b", eb);

        // Reset in the 4th conversion cycle aborts without a result.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hC8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid.ready", 12'(in_ready), 12'd1);
        chk("mid.valid", 12'(out_valid), 12'd0);
        check_outs("mid", rst_vec);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        chk("mid.no_pulse", 12'(pulses), 12'd0);
        chk("mid.bcd_held", out_bcd, 12'h000);
        do_convert("after_rst", ref_model(8'h2A));
        chk("after_rst.bcd", out_bcd, 12'h042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
